// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, widths, request record and
// the arbiter state encoding used by the shared-ALU front end.
package alu_pkg;

   localparam int ALU_DATA_W = 32;
   localparam int ALU_OP_W   = 5;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 5'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 5'd3;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 5'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 5'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SLL = 5'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRL = 5'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SRA = 5'd8;
   localparam logic [ALU_OP_W-1:0] ALU_NOR = 5'd9;
   localparam logic [ALU_OP_W-1:0] ALU_SGE = 5'd10;

   // Highest defined opcode; anything above it is reported as illegal.
   localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 5'b01010;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
      logic [ALU_OP_W-1:0]   op;
   } alu_req_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority picker: starting at i_ptr and wrapping,
// grants the first asserted request. Returns a one-hot grant and its index.
module rr_arbiter
#(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
)
(
   input  logic [N-1:0]    i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [N-1:0]    o_grant,
   output logic [ID_W-1:0] o_id,
   output logic            o_any
);

   // Walk the requesters from the pointer upward, modulo N, and keep the first hit.
   always_comb begin : pick
      int idx;
      o_grant = '0;
      o_id    = '0;
      o_any   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(i_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!o_any && i_req[idx]) begin
            o_any        = 1'b1;
            o_grant[idx] = 1'b1;
            o_id         = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters. One transaction is in flight at a
// time: accept in IDLE, drive the ALU for one EXEC cycle, hold the response in
// RESP until the granted requester takes it, then rotate priority.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 5,
   parameter int ID_W    = $clog2(NUM_REQ)
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_zero,
   output logic                      rsp_illegal,
   output logic [DATA_W-1:0]         alu_operand_a,
   output logic [DATA_W-1:0]         alu_operand_b,
   output logic [OP_W-1:0]           alu_op,
   input  logic [DATA_W-1:0]         alu_result,
   input  logic                      alu_zero,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id
);

   arb_state_e          r_state;
   arb_state_e          w_nextState;
   logic [ID_W-1:0]     r_rrPtr;
   logic [ID_W-1:0]     r_grantId;
   logic [DATA_W-1:0]   r_opA;
   logic [DATA_W-1:0]   r_opB;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_result;
   logic                r_zero;
   logic                r_illegal;
   logic [NUM_REQ-1:0]  w_winOneHot;
   logic [ID_W-1:0]     w_winId;
   logic                w_anyReq;
   logic                w_rspAccept;
   logic                w_illegalOp;

   rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_rrPtr),
      .o_grant (w_winOneHot),
      .o_id    (w_winId),
      .o_any   (w_anyReq)
   );

   assign w_illegalOp   = (r_op > OP_W'(ALU_OP_MAX));
   assign alu_operand_a = r_opA;
   assign alu_operand_b = r_opB;
   assign alu_op        = r_op;
   assign rsp_result    = r_result;
   assign rsp_zero      = r_zero;
   assign rsp_illegal   = r_illegal;
   assign grant_id      = r_grantId;
   assign busy          = (r_state != IDLE);

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // Next state plus the handshake strobes seen by the requesters.
   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      rsp_valid   = '0;
      w_rspAccept = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = w_winOneHot;
            if (w_anyReq) w_nextState = EXEC;
         end
         EXEC: w_nextState = RESP;
         RESP: begin
            rsp_valid[r_grantId] = 1'b1;
            w_rspAccept          = rsp_ready[r_grantId];
            if (w_rspAccept) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Operand capture on accept, result capture after EXEC, pointer rotation on response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rrPtr   <= '0;
         r_grantId <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_op      <= '0;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_opA     <= req_a[w_winId*DATA_W +: DATA_W];
                  r_opB     <= req_b[w_winId*DATA_W +: DATA_W];
                  r_op      <= req_op[w_winId*OP_W +: OP_W];
                  r_grantId <= w_winId;
               end
            end
            EXEC: begin
               if (w_illegalOp) begin
                  r_result  <= '0;
                  r_zero    <= 1'b1;
                  r_illegal <= 1'b1;
               end else begin
                  r_result  <= alu_result;
                  r_zero    <= alu_zero;
                  r_illegal <= 1'b0;
               end
            end
            RESP: begin
               if (w_rspAccept) begin
                  r_rrPtr <= (r_grantId == ID_W'(NUM_REQ-1)) ? '0 : r_grantId + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU on the ALU ports, a vector table of
// single transactions, and hand sequences for round-robin, backpressure,
// reset and pointer wrap. Responses are checked against a scoreboard queue.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int OW = 5;
   localparam int IW = 2;

   typedef struct {
      int          id;
      alu_req_t    req;
      logic [31:0] expRes;
      logic        expZero;
      logic        expIll;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        z;
      logic        ill;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a;
   logic [NR*DW-1:0]  req_b;
   logic [NR*OW-1:0]  req_op;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready;
   logic [DW-1:0]     rsp_result;
   logic              rsp_zero;
   logic              rsp_illegal;
   logic [DW-1:0]     alu_operand_a;
   logic [DW-1:0]     alu_operand_b;
   logic [OW-1:0]     alu_op;
   logic [DW-1:0]     alu_result;
   logic              alu_zero;
   logic              busy;
   logic [IW-1:0]     grant_id;

   exp_t scbQ[$];
   int   hsIds[$];
   int   hsCyc[$];
   int   cycle = 0;
   int   total = 0;
   int   bad = 0;
   int   acceptCyc = 0;
   vec_t vecs[14];

   alu_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .OP_W    (OW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_op        (req_op),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_zero      (rsp_zero),
      .rsp_illegal   (rsp_illegal),
      .alu_operand_a (alu_operand_a),
      .alu_operand_b (alu_operand_b),
      .alu_op        (alu_op),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle counter used for latency and spacing checks.
   always @(posedge clk) cycle = cycle + 1;

   // Behavioural ALU; undefined opcodes return a nonzero junk value the DUT must mask.
   always_comb begin
      alu_result = 32'hDEADBEEF;
      case (alu_op)
         ALU_ADD: alu_result = alu_operand_a + alu_operand_b;
         ALU_SUB: alu_result = alu_operand_a - alu_operand_b;
         ALU_AND: alu_result = alu_operand_a & alu_operand_b;
         ALU_OR:  alu_result = alu_operand_a | alu_operand_b;
         ALU_XOR: alu_result = alu_operand_a ^ alu_operand_b;
         ALU_SLT: alu_result = {31'b0, $signed(alu_operand_a) < $signed(alu_operand_b)};
         ALU_SLL: alu_result = alu_operand_a << alu_operand_b[4:0];
         ALU_SRL: alu_result = alu_operand_a >> alu_operand_b[4:0];
         ALU_SRA: alu_result = $unsigned($signed(alu_operand_a) >>> alu_operand_b[4:0]);
         ALU_NOR: alu_result = ~(alu_operand_a | alu_operand_b);
         ALU_SGE: alu_result = {31'b0, $signed(alu_operand_a) >= $signed(alu_operand_b)};
         default: alu_result = 32'hDEADBEEF;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   function automatic logic [NR-1:0] oneHot(input int i);
      logic [NR-1:0] one;
      one = 1;
      return one << i;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic setReq(input int id, input alu_req_t r);
      req_a[id*DW +: DW]  = r.a;
      req_b[id*DW +: DW]  = r.b;
      req_op[id*OW +: OW] = r.op;
   endtask

   task automatic pushExp(input int id, input logic [31:0] res, input logic z, input logic ill);
      exp_t e;
      e.id  = id;
      e.res = res;
      e.z   = z;
      e.ill = ill;
      scbQ.push_back(e);
   endtask

   // Response monitor: every response handshake is matched against the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
         checkOutput("scb nonempty", 64'(scbQ.size() != 0), 64'd1);
         if (scbQ.size() != 0) begin
            e = scbQ.pop_front();
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(oneHot(e.id)));
            checkOutput("rsp_result", 64'(rsp_result), 64'(e.res));
            checkOutput("rsp_zero", 64'(rsp_zero), 64'(e.z));
            checkOutput("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
         end
         hsIds.push_back(int'(grant_id));
         hsCyc.push_back(cycle);
      end
   end

   task automatic resetDut();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Drive one request alone, wait for its grant, queue its expected response.
   task automatic applyStimulus(input vec_t v);
      int n;
      setReq(v.id, v.req);
      req_valid[v.id] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!req_ready[v.id] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("accept", 64'(req_ready), 64'(oneHot(v.id)));
      acceptCyc = cycle;
      pushExp(v.id, v.expRes, v.expZero, v.expIll);
      @(posedge clk);
      #1;
      req_valid[v.id] = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (scbQ.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain", 64'(scbQ.size()), 64'd0);
   endtask

   // Two requesters valid together; the first id must win, then the second.
   task automatic applyPair(input string name, input int idA, input int idB);
      int n;
      req_valid = oneHot(idA) | oneHot(idB);
      @(negedge clk);
      checkOutput({name, " first"}, 64'(req_ready), 64'(oneHot(idA)));
      @(posedge clk);
      #1;
      req_valid[idA] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!req_ready[idB] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " second"}, 64'(req_ready), 64'(oneHot(idB)));
      @(posedge clk);
      #1;
      req_valid[idB] = 1'b0;
      waitDrain();
   endtask

   // Watchdog so a stuck DUT still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int hsBefore;
      vecs[0]  = '{2, '{32'd10, 32'd15, ALU_ADD}, 32'd25, 1'b0, 1'b0};
      vecs[1]  = '{0, '{32'd5, 32'd5, ALU_SUB}, 32'd0, 1'b1, 1'b0};
      vecs[2]  = '{1, '{32'h0000F0F0, 32'h0000FF00, ALU_AND}, 32'h0000F000, 1'b0, 1'b0};
      vecs[3]  = '{0, '{32'hFFFF0000, 32'hFFFFFFFF, ALU_XOR}, 32'h0000FFFF, 1'b0, 1'b0};
      vecs[4]  = '{1, '{32'hFFFFFFFF, 32'd1, ALU_SLT}, 32'd1, 1'b0, 1'b0};
      vecs[5]  = '{2, '{32'd1, 32'd31, ALU_SLL}, 32'h80000000, 1'b0, 1'b0};
      vecs[6]  = '{3, '{32'h80000000, 32'd4, ALU_SRL}, 32'h08000000, 1'b0, 1'b0};
      vecs[7]  = '{1, '{32'hFFFFFFF8, 32'd3, ALU_SRA}, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[8]  = '{0, '{32'd0, 32'd0, ALU_NOR}, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[9]  = '{2, '{32'd3, 32'd5, ALU_SGE}, 32'd0, 1'b1, 1'b0};
      vecs[10] = '{1, '{32'd5, 32'd5, ALU_SGE}, 32'd1, 1'b0, 1'b0};
      vecs[11] = '{3, '{32'd10, 32'd5, 5'b11111}, 32'd0, 1'b1, 1'b1};
      vecs[12] = '{3, '{32'd0, 32'hABCDE123, ALU_OR}, 32'hABCDE123, 1'b0, 1'b0};
      vecs[13] = '{2, '{32'd1, 32'd1, 5'b01011}, 32'd0, 1'b1, 1'b1};

      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '1;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      #2;
      checkOutput("reset req_ready", 64'(req_ready), 64'd0);
      checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset grant_id", 64'(grant_id), 64'd0);
      checkOutput("reset rsp_result", 64'(rsp_result), 64'd0);
      checkOutput("reset rsp_zero", 64'(rsp_zero), 64'd1);
      checkOutput("reset rsp_illegal", 64'(rsp_illegal), 64'd0);
      checkOutput("reset alu_a", 64'(alu_operand_a), 64'd0);
      checkOutput("reset alu_op", 64'(alu_op), 64'd0);
      resetDut();

      $display("[TB] vector table");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         waitDrain();
         checkOutput("latency", 64'(hsCyc[$] - acceptCyc), 64'd2);
         checkOutput("grant_id", 64'(grant_id), 64'(vecs[i].id));
      end

      $display("[TB] all four requesters contend");
      resetDut();
      hsIds.delete();
      hsCyc.delete();
      for (int i = 0; i < NR; i++) setReq(i, '{32'd5, 32'd5, ALU_SUB});
      for (int k = 0; k < 5; k++) pushExp(k % NR, 32'd0, 1'b1, 1'b0);
      req_valid = '1;
      n = 0;
      while (hsIds.size() < 5 && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = '0;
      checkOutput("rr count", 64'(hsIds.size()), 64'd5);
      for (int k = 0; k < 5; k++) checkOutput("rr order", 64'(hsIds[k]), 64'(k % NR));
      for (int k = 1; k < 5; k++) checkOutput("rr spacing", 64'(hsCyc[k] - hsCyc[k-1]), 64'd3);
      waitDrain();

      $display("[TB] backpressure");
      rsp_ready = 4'b1101;
      setReq(1, '{32'hFFFFFFF8, 32'd3, ALU_SRA});
      setReq(0, '{32'd1, 32'd2, ALU_ADD});
      req_valid = 4'b0011;
      @(negedge clk);
      checkOutput("bp accept 1", 64'(req_ready), 64'(4'b0010));
      pushExp(1, 32'hFFFFFFFF, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid[1] && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp hold valid", 64'(rsp_valid), 64'(4'b0010));
         checkOutput("bp hold result", 64'(rsp_result), 64'hFFFFFFFF);
         checkOutput("bp req0 blocked", 64'(req_ready), 64'd0);
         @(posedge clk);
         #1;
         if (k < 4) @(negedge clk);
      end
      rsp_ready = '1;
      pushExp(0, 32'd3, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("bp grant 0", 64'(req_ready), 64'(4'b0001));
      checkOutput("bp grant 0 cycle", 64'(cycle - hsCyc[$]), 64'd1);
      @(posedge clk);
      #1;
      req_valid = '0;
      waitDrain();

      $display("[TB] reset during EXEC");
      setReq(2, '{32'd7, 32'd8, ALU_ADD});
      req_valid[2] = 1'b1;
      @(negedge clk);
      checkOutput("rst accept 2", 64'(req_ready), 64'(4'b0100));
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      hsBefore = hsIds.size();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst busy", 64'(busy), 64'd0);
      checkOutput("rst rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst no response", 64'(hsIds.size()), 64'(hsBefore));
      setReq(1, '{32'h0000000F, 32'h00000003, ALU_XOR});
      setReq(3, '{32'd2, 32'd2, ALU_ADD});
      pushExp(1, 32'h0000000C, 1'b0, 1'b0);
      pushExp(3, 32'd4, 1'b0, 1'b0);
      applyPair("post-reset", 1, 3);

      $display("[TB] pointer wrap");
      setReq(0, '{32'h000000FF, 32'h0000000F, ALU_AND});
      setReq(2, '{32'd3, 32'd5, ALU_SUB});
      pushExp(0, 32'h0000000F, 1'b0, 1'b0);
      pushExp(2, 32'hFFFFFFFE, 1'b0, 1'b0);
      applyPair("wrap", 0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one RV ALU instance between NUM_REQ independent requesters, for example the integer pipe, the address-generation unit and the debug port.
- Uses round-robin arbitration with one transaction in flight at a time.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Drives the ALU operand/op ports from internal registers and captures result and zero flag into a response register.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 5, ALU opcode width
ID_W, $clog2(NUM_REQ), grant index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero)
req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B
req_op  in  NUM_REQ*OP_W  packed opcode
rsp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero)
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_result  out  DATA_W  result, shared bus, qualified by rsp_valid
rsp_zero  out  1  zero flag of result
rsp_illegal  out  1  opcode was not a defined ALU op
alu_operand_a  out  DATA_W  to ALU operand_a
alu_operand_b  out  DATA_W  to ALU operand_b
alu_op  out  OP_W  to ALU alu_op
alu_result  in  DATA_W  from ALU result (combinational within cycle)
alu_zero  in  1  from ALU zero
busy  out  1  state != IDLE
grant_id  out  ID_W  index of current/last granted requester

Behaviour:
- Reset (async, active-high):
  - state=IDLE and rr_ptr=0.
  - Operand/op registers, grant_id, rsp_result and rsp_illegal are 0; rsp_zero is 1.
  - req_ready, rsp_valid and busy are 0.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits of req_ready are 0.
  - On handshake: latch a/b/op of the winner, set grant_id=winner, go to EXEC.
  - With no req_valid set, stay in IDLE and keep req_ready=0.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the registers at all times.
  - At the end of EXEC, capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
  - If op > 5'b01010 (undefined): rsp_illegal=1, rsp_result=0, rsp_zero=1, regardless of ALU outputs.
- RESP:
  - rsp_valid[grant_id]=1.
  - Hold result, zero and illegal stable until rsp_ready[grant_id]=1.
  - On that handshake: rr_ptr = (grant_id+1) mod NUM_REQ, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency: request accepted in cycle t, rsp_valid high in cycle t+2. Minimum issue interval is 3 cycles (back-to-back when rsp_ready is held high).
- req_ready=0 in EXEC and RESP. Requesters must hold valid and data until accepted. Dropping req_valid before the handshake is legal; that request is simply not granted.
- Simultaneous requests from all requesters are served in rotating order, so no requester waits more than NUM_REQ transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset asserted mid-transaction discards the in-flight operation with no response. The first grant after reset goes to the lowest-index valid requester.
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8, NOR=9, SGE=10. Opcodes 11..31 are illegal.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams ALU_ADD..ALU_SGE;
  - ALU_OP_MAX=5'b01010;
  - the ALU_OP_W and DATA_W constants;
  - typedef alu_req_t {a, b, op};
  - typedef arb_state_e {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter: a combinational round-robin priority picker. It takes the request vector and rr_ptr and returns a one-hot grant plus an encoded index. It is reusable elsewhere in the design.

Test Plan:
- Single request: requester 2 sends ADD 10,15 with rsp_ready=1 → req_ready[2] in the accept cycle, rsp_valid=4'b0100 two cycles later, rsp_result=25, rsp_zero=0, rsp_illegal=0.
- All four requesters hold SUB 5,5 with rsp_ready=1 → grant order 0,1,2,3,0; each response has result 0 and zero=1; handshakes spaced exactly 3 cycles apart.
- Backpressure: requester 1 sends SRA 0xFFFFFFF8,3 with rsp_ready[1]=0 for 5 cycles → rsp_valid[1] stays high with result 0xFFFFFFFF stable. req_ready stays 0 for requester 0, which is requesting throughout. Requester 0 is granted in the cycle after rsp_ready[1] rises.
- Illegal opcode: requester 3 sends op 5'b11111 with a=10, b=5 → rsp_illegal=1, rsp_result=0, rsp_zero=1. The next op from requester 3 (OR 0,0xABCDE123) returns 0xABCDE123 with illegal=0.
- Reset mid-EXEC: assert rst asynchronously between clock edges → busy, rsp_valid and req_ready go to 0 immediately and no response is produced. After release, requesters 1 and 3 both valid → requester 1 is granted first (rr_ptr=0).
- Wrap: grant requester 3 and complete it, then requesters 0 and 2 both valid → requester 0 is granted (rr_ptr wrapped to 0).
